spi_master_ng: RTL and testbench

//  Parametrised SPI master: configurable word width, all four CPOL/CPHA modes,
//  MSB/LSB-first, multiple chip selects. A single-cycle clock enable replaces a

---
 rtl/spi_master_ng_if.sv | 29 ++
 rtl/spi_master_ng.sv | 149 ++++++++++++++
 tb/tb_spi_master_ng.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ng_if.sv
// rtl/spi_master_ng_if.sv - CPU-side control/status bundle for spi_master_ng
interface spi_master_ng_if #(
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 8,
    parameter int NUM_CS   = 4,
    parameter int CS_BITS  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic [DIV_BITS-1:0] divisor;
    logic [1:0]          mode;
    logic                lsb_first;
    logic [CS_BITS-1:0]  cs_sel;
    logic                cs_hold;
    logic [NUM_CS-1:0]   cs_manual;
    logic                start;
    logic [WIDTH-1:0]    data_tx;
    logic [WIDTH-1:0]    data_rx;
    logic                busy;
    logic                done;

    modport master (
        output divisor, mode, lsb_first, cs_sel, cs_hold, cs_manual, start, data_tx,
        input  data_rx, busy, done
    );

    modport slave (
        input  divisor, mode, lsb_first, cs_sel, cs_hold, cs_manual, start, data_tx,
        output data_rx, busy, done
    );
endinterface

// File: rtl/spi_master_ng.sv
// rtl/spi_master_ng.sv - SPI master, all CPOL/CPHA modes, clock-enable divider on raw_clk
// Define SPI_CS_AUTO_EN for FSM-driven chip selects; otherwise cs_n follows cs_manual.
module spi_master_ng #(
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 8,
    parameter int NUM_CS   = 4
) (
    input  logic              raw_clk,
    input  logic              reset,
    spi_master_ng_if.slave    bus,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, LAG} state_t;

    localparam int HC_BITS = $clog2(2 * WIDTH);
    localparam logic [HC_BITS-1:0] LAST_HALF = HC_BITS'(2 * WIDTH - 1);

    state_t              state;
    logic [DIV_BITS-1:0] div_q;
    logic [DIV_BITS-1:0] div_cnt;
    logic [HC_BITS-1:0]  half_cnt;
    logic                cpha_q;
    logic                lsb_q;
    logic [WIDTH-1:0]    tx_sr;
    logic [WIDTH-1:0]    rx_sr;
    logic [WIDTH-1:0]    data_rx_q;
    logic                busy_q;
    logic                done_q;
    logic [NUM_CS-1:0]   cs_n_q;
    logic [WIDTH-1:0]    tx_first;
    logic                tick;
    logic                leading;
    logic                do_sample;
    logic                do_shift;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Internally everything shifts MSB-first; lsb_first is handled by reversing on load and unload.
    assign tx_first  = bus.lsb_first ? bit_rev(bus.data_tx) : bus.data_tx;
    assign tick      = (div_cnt == '0);
    assign leading   = ~half_cnt[0];
    // CPHA=1 keeps the first bit on the first leading edge since LEAD already drove it.
    assign do_sample = cpha_q ? ~leading : leading;
    assign do_shift  = cpha_q ? (leading && (half_cnt != '0)) : ~leading;

`ifdef SPI_CS_AUTO_EN
    localparam int CS_BITS = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam logic [CS_BITS:0] NUM_CS_W = (CS_BITS + 1)'(NUM_CS);
    logic cs_hold_q;
    logic unused_cfg;
    assign unused_cfg = ^bus.cs_manual;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.cs_sel, bus.cs_hold};
`endif

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state     <= IDLE;
            div_q     <= '0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            data_rx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n_q    <= '1;
`ifdef SPI_CS_AUTO_EN
            cs_hold_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifndef SPI_CS_AUTO_EN
            cs_n_q <= ~bus.cs_manual;
`endif
            case (state)
                IDLE: begin
                    sclk     <= bus.mode[1];
                    div_cnt  <= '0;
                    half_cnt <= '0;
                    if (bus.start) begin
                        state   <= LEAD;
                        busy_q  <= 1'b1;
                        div_q   <= bus.divisor;
                        div_cnt <= bus.divisor;
                        cpha_q  <= bus.mode[0];
                        lsb_q   <= bus.lsb_first;
                        mosi    <= tx_first[WIDTH-1];
                        tx_sr   <= {tx_first[WIDTH-2:0], 1'b0};
                        rx_sr   <= '0;
`ifdef SPI_CS_AUTO_EN
                        cs_hold_q <= bus.cs_hold;
                        if ({1'b0, bus.cs_sel} < NUM_CS_W)
                            cs_n_q <= ~(NUM_CS'(1) << bus.cs_sel);
                        else
                            cs_n_q <= '1;
`endif
                    end
                end
                LEAD: begin
                    if (tick) state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        half_cnt <= half_cnt + HC_BITS'(1);
                        if (do_sample) rx_sr <= {rx_sr[WIDTH-2:0], miso};
                        if (do_shift) begin
                            mosi  <= tx_sr[WIDTH-1];
                            tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                        end
                        if (half_cnt == LAST_HALF) state <= LAG;
                    end
                end
                LAG: begin
                    if (tick) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        mosi      <= 1'b0;
                        data_rx_q <= lsb_q ? bit_rev(rx_sr) : rx_sr;
`ifdef SPI_CS_AUTO_EN
                        if (!cs_hold_q) cs_n_q <= '1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE) div_cnt <= tick ? div_q : div_cnt - DIV_BITS'(1);
        end
    end

    assign bus.data_rx = data_rx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign cs_n        = cs_n_q;
endmodule

// File: tb/tb_spi_master_ng.sv
// tb/tb_spi_master_ng.sv - table-driven directed bench for spi_master_ng
module tb_spi_master_ng;
    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;

    spi_master_ng_if #(.WIDTH(8), .DIV_BITS(8), .NUM_CS(4)) bus ();

    spi_master_ng #(.WIDTH(8), .DIV_BITS(8), .NUM_CS(4)) dut (
        .raw_clk (clk),
        .reset   (reset),
        .bus     (bus),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Simple SPI slave: shifts slv_pat out MSB-first on the edges its mode dictates.
    logic       use_slv = 1'b0;
    logic [7:0] slv_pat = 8'h00;
    logic       slv_cpha = 1'b0;
    logic       slv_miso = 1'b0;
    logic       slv_busy_q = 1'b0;
    logic       slv_sclk_q = 1'b0;
    int         slv_edges = 0;

    always @(sclk or bus.busy) begin
        if (bus.busy && !slv_busy_q) begin
            slv_edges = 0;
            slv_miso  = slv_cpha ? 1'b0 : slv_pat[7];
        end else if (bus.busy && (sclk !== slv_sclk_q)) begin
            slv_edges++;
            if (slv_cpha && slv_edges[0])
                slv_miso = slv_pat[7 - (slv_edges - 1) / 2];
            else if (!slv_cpha && !slv_edges[0] && slv_edges < 16)
                slv_miso = slv_pat[7 - slv_edges / 2];
        end
        slv_busy_q = bus.busy;
        slv_sclk_q = sclk;
    end

    assign miso = use_slv ? slv_miso : mosi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int         bcyc, tog, gmin, gmax, runs;
    logic       fm, dh, dl, se;
    logic [3:0] csl;
    logic [7:0] rx;

    // Entered and left on a negedge; samples every negedge while busy.
    task automatic xfer(input logic [1:0] m, input logic lsb, input logic [7:0] dv,
                        input logic [7:0] tx, input logic slv, input logic [7:0] pat,
                        input logic [1:0] csel, input logic hold, input logic poke);
        logic ps, pm;
        int   gap;
        bus.mode = m; bus.lsb_first = lsb; bus.divisor = dv; bus.data_tx = tx;
        bus.cs_sel = csel; bus.cs_hold = hold;
        use_slv = slv; slv_pat = pat; slv_cpha = m[0];
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        fm = mosi; csl = cs_n; ps = sclk; pm = mosi;
        runs = mosi ? 1 : 0;
        bcyc = 0; tog = 0; gap = 0; gmin = 100000; gmax = 0;
        while (bus.busy === 1'b1 && bcyc < 3000) begin
            bcyc++;
            if (poke && bcyc == 10) begin
                bus.data_tx = 8'hFF;
                bus.start   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            gap++;
            if (sclk !== ps) begin
                if (tog > 0) begin
                    if (gap < gmin) gmin = gap;
                    if (gap > gmax) gmax = gap;
                end
                tog++; gap = 0; ps = sclk;
            end
            if (mosi && !pm) runs++;
            pm = mosi;
        end
        bus.start = 1'b0;
        dh = bus.done; se = sclk; rx = bus.data_rx;
        @(negedge clk);
        dl = bus.done;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       lsb;
        logic [7:0] dv;
        logic [7:0] tx;
        logic       slv;
        logic [7:0] pat;
        logic [7:0] exp_rx;
        int         exp_busy;
        logic       exp_first;
        int         exp_runs;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 1'b0, 8'd0, 8'hA5, 1'b0, 8'h00, 8'hA5, 18, 1'b1, 4};
        vecs[1] = '{2'd3, 1'b0, 8'd3, 8'h3C, 1'b1, 8'h96, 8'h96, 72, 1'b0, 1};
        vecs[2] = '{2'd0, 1'b1, 8'd1, 8'h01, 1'b0, 8'h00, 8'h01, 36, 1'b1, 1};
        vecs[3] = '{2'd1, 1'b0, 8'd1, 8'hC3, 1'b0, 8'h00, 8'hC3, 36, 1'b1, 2};
        vecs[4] = '{2'd2, 1'b1, 8'd0, 8'h96, 1'b0, 8'h00, 8'h96, 18, 1'b0, 3};

        reset = 1'b1;
        bus.divisor = '0; bus.mode = '0; bus.lsb_first = 1'b0; bus.cs_sel = '0;
        bus.cs_hold = 1'b0; bus.cs_manual = '0; bus.start = 1'b0; bus.data_tx = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst sclk", sclk, 1'b0);
        chk("rst mosi", mosi, 1'b0);
        chk("rst cs_n", cs_n, 4'hF);
        chk("rst data_rx", bus.data_rx, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            bus.mode = vecs[i].mode;
            @(negedge clk);
            chk($sformatf("v%0d idle_sclk", i), sclk, vecs[i].mode[1]);
            xfer(vecs[i].mode, vecs[i].lsb, vecs[i].dv, vecs[i].tx, vecs[i].slv,
                 vecs[i].pat, 2'd0, 1'b0, 1'b0);
            chk($sformatf("v%0d data_rx", i), rx, vecs[i].exp_rx);
            chk($sformatf("v%0d busy_cycles", i), bcyc, vecs[i].exp_busy);
            chk($sformatf("v%0d sclk_edges", i), tog, 16);
            chk($sformatf("v%0d half_min", i), gmin, vecs[i].dv + 1);
            chk($sformatf("v%0d half_max", i), gmax, vecs[i].dv + 1);
            chk($sformatf("v%0d first_mosi", i), fm, vecs[i].exp_first);
            chk($sformatf("v%0d mosi_runs", i), runs, vecs[i].exp_runs);
            chk($sformatf("v%0d done_pulse", i), dh, 1'b1);
            chk($sformatf("v%0d done_clear", i), dl, 1'b0);
            chk($sformatf("v%0d end_sclk", i), se, vecs[i].mode[1]);
        end

`ifdef SPI_CS_AUTO_EN
        xfer(2'd0, 1'b0, 8'd0, 8'h81, 1'b0, 8'h00, 2'd2, 1'b1, 1'b0);
        chk("acs1 lead", csl, 4'b1011);
        chk("acs1 held", cs_n, 4'b1011);
        chk("acs1 rx", rx, 8'h81);
        xfer(2'd0, 1'b0, 8'd0, 8'h42, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
        chk("acs2 lead", csl, 4'b1011);
        chk("acs2 release", cs_n, 4'hF);
        chk("acs2 rx", rx, 8'h42);
`else
        bus.cs_manual = 4'b0100;
        chk("mcs lag", cs_n, 4'hF);
        @(negedge clk);
        chk("mcs set", cs_n, 4'b1011);
        bus.cs_manual = 4'b0000;
        @(negedge clk);
        chk("mcs clear", cs_n, 4'hF);
`endif

        xfer(2'd0, 1'b0, 8'd1, 8'h5A, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        chk("ign rx", rx, 8'h5A);
        chk("ign busy_cycles", bcyc, 36);
        begin
            int extra = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.busy) extra++;
            end
            chk("ign no_restart", extra, 0);
            chk("ign rx_kept", bus.data_rx, 8'h5A);
        end

        bus.mode = 2'd2; bus.divisor = 8'd1; bus.data_tx = 8'hFF; bus.lsb_first = 1'b0;
        bus.cs_manual = 4'b0010; bus.cs_sel = 2'd1; bus.cs_hold = 1'b0; use_slv = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("rmid busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rmid busy", bus.busy, 1'b0);
        chk("rmid done", bus.done, 1'b0);
        chk("rmid sclk", sclk, 1'b0);
        chk("rmid mosi", mosi, 1'b0);
        chk("rmid cs_n", cs_n, 4'hF);
        chk("rmid data_rx", bus.data_rx, 8'h00);
        reset = 1'b0;
        bus.cs_manual = 4'b0000;
        begin
            int dcnt = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (bus.done) dcnt++;
            end
            chk("rmid no_done", dcnt, 0);
        end
        xfer(2'd0, 1'b0, 8'd0, 8'h6E, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        chk("rpost rx", rx, 8'h6E);
        chk("rpost busy_cycles", bcyc, 18);
        chk("rpost done_pulse", dh, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
